// File: rtl/io_wr_core_regs.sv
// Core-resident I/O registers SPL/SPH/SREG: write decode plus arbitration
// against stack stepping, ALU flag updates and interrupt I-bit handling.
module io_wr_core_regs #(
  parameter int unsigned SP_BITS     = 12,
  parameter logic [15:0] SP_RESET    = 16'h08FF,
  parameter logic [15:0] STACK_LIMIT = 16'h0100
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic [5:0]  adr,
  input  logic        iowe,
  input  logic [7:0]  dbusout,
  input  logic        sp_dec,
  input  logic        sp_inc,
  input  logic [1:0]  sp_step,
  input  logic [7:0]  alu_flags,
  input  logic [7:0]  alu_flags_we,
  input  logic        irq_ack,
  input  logic        reti_exec,
  output logic [7:0]  spl_out,
  output logic [7:0]  sph_out,
  output logic [7:0]  sreg_out,
  output logic [15:0] sp_out,
  output logic        sp_chg,
  output logic        sp_ovf
);

  localparam logic [15:0] SP_MASK  = 16'((32'd1 << SP_BITS) - 32'd1);
  localparam logic [7:0]  SPH_MASK = SP_MASK[15:8];
  localparam logic [5:0]  ADR_SPL  = 6'h3D;
  localparam logic [5:0]  ADR_SPH  = 6'h3E;
  localparam logic [5:0]  ADR_SREG = 6'h3F;
  localparam int unsigned I_BIT    = 7;

  logic [15:0] sp_q, sp_nxt;
  logic [7:0]  sreg_q, sreg_nxt;
  logic        chg_q, ovf_q, ovf_nxt;

  logic        wr_spl, wr_sph, wr_sreg, sp_wr;
  logic        step_ok, do_dec, do_inc, dec_wrap;
  logic [15:0] step16, dec_val, inc_val;

  // Write decode and stepping qualifiers
  always_comb begin
    wr_spl   = iowe && (adr == ADR_SPL);
    wr_sph   = iowe && (adr == ADR_SPH);
    wr_sreg  = iowe && (adr == ADR_SREG);
    sp_wr    = wr_spl || wr_sph;
    step_ok  = (sp_step == 2'd1) || (sp_step == 2'd2);
    step16   = 16'(sp_step);
    do_dec   = !sp_wr && sp_dec && !sp_inc && step_ok;
    do_inc   = !sp_wr && sp_inc && !sp_dec && step_ok;
    dec_val  = (sp_q - step16) & SP_MASK;
    inc_val  = (sp_q + step16) & SP_MASK;
    // sp_q is always masked, so borrowing past zero is exactly sp_q < step
    dec_wrap = sp_q < step16;
  end

  // Next SP / overflow flag
  always_comb begin
    sp_nxt  = sp_q;
    ovf_nxt = ovf_q;
    if (wr_spl) begin
      sp_nxt[7:0] = dbusout;
    end else if (wr_sph) begin
      sp_nxt[15:8] = dbusout & SPH_MASK;
      ovf_nxt      = 1'b0;
    end else if (do_dec) begin
      sp_nxt = dec_val;
      if (dec_wrap || (dec_val < STACK_LIMIT)) ovf_nxt = 1'b1;
    end else if (do_inc) begin
      sp_nxt = inc_val;
    end
  end

  // Next SREG: I/O write, then irq_ack, then reti_exec, then ALU
  always_comb begin
    sreg_nxt = sreg_q;
    if (wr_sreg) begin
      sreg_nxt = dbusout;
    end else begin
      sreg_nxt = (sreg_q & ~alu_flags_we) | (alu_flags & alu_flags_we);
      if (reti_exec) sreg_nxt[I_BIT] = 1'b1;
      if (irq_ack)   sreg_nxt[I_BIT] = 1'b0;
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      sp_q   <= SP_RESET & SP_MASK;
      sreg_q <= 8'h00;
      chg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_nxt;
      sreg_q <= sreg_nxt;
      chg_q  <= (sp_nxt != sp_q);
      ovf_q  <= ovf_nxt;
    end
  end

  assign sp_out   = sp_q;
  assign spl_out  = sp_q[7:0];
  assign sph_out  = sp_q[15:8];
  assign sreg_out = sreg_q;
  assign sp_chg   = chg_q;
  assign sp_ovf   = ovf_q;

endmodule

// File: tb/tb_io_wr_core_regs.sv
// Randomized bench for io_wr_core_regs against an integer-arithmetic model,
// with directed literal checks covering reset, masking, wrap and priorities.
module tb_io_wr_core_regs;

  logic        cp2 = 1'b0;
  logic        ireset;
  logic [5:0]  adr;
  logic        iowe;
  logic [7:0]  dbusout;
  logic        sp_dec, sp_inc;
  logic [1:0]  sp_step;
  logic [7:0]  alu_flags, alu_flags_we;
  logic        irq_ack, reti_exec;
  logic [7:0]  spl_out, sph_out, sreg_out;
  logic [15:0] sp_out;
  logic        sp_chg, sp_ovf;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state
  int       m_sp   = 'h8FF;
  logic [7:0] m_sreg = 8'h00;
  bit       m_chg  = 1'b0;
  bit       m_ovf  = 1'b0;

  io_wr_core_regs dut (
    .cp2(cp2), .ireset(ireset), .adr(adr), .iowe(iowe), .dbusout(dbusout),
    .sp_dec(sp_dec), .sp_inc(sp_inc), .sp_step(sp_step),
    .alu_flags(alu_flags), .alu_flags_we(alu_flags_we),
    .irq_ack(irq_ack), .reti_exec(reti_exec),
    .spl_out(spl_out), .sph_out(sph_out), .sreg_out(sreg_out),
    .sp_out(sp_out), .sp_chg(sp_chg), .sp_ovf(sp_ovf)
  );

  always #5 cp2 = ~cp2;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural update from the rules, using plain integer arithmetic
  task automatic model_step();
    int old, r;
    if (ireset) begin
      m_sp = 'h8FF; m_sreg = 8'h00; m_chg = 0; m_ovf = 0;
      return;
    end
    old = m_sp;
    if (iowe && adr == 6'h3D) begin
      m_sp = (m_sp / 256) * 256 + int'(dbusout);
    end else if (iowe && adr == 6'h3E) begin
      m_sp = (int'(dbusout) % 16) * 256 + (m_sp % 256);
      m_ovf = 0;
    end else if ((sp_dec != sp_inc) && (sp_step == 1 || sp_step == 2)) begin
      if (sp_dec) begin
        r = m_sp - int'(sp_step);
        if (r < 0) begin r = r + 4096; m_ovf = 1; end
        if (r < 256) m_ovf = 1;
        m_sp = r;
      end else begin
        m_sp = (m_sp + int'(sp_step)) % 4096;
      end
    end
    m_chg = (m_sp != old);
    if (iowe && adr == 6'h3F) begin
      m_sreg = dbusout;
    end else begin
      for (int b = 0; b < 8; b++) if (alu_flags_we[b]) m_sreg[b] = alu_flags[b];
      if (reti_exec) m_sreg[7] = 1'b1;
      if (irq_ack)   m_sreg[7] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge cp2);
    #1;
    model_step();
    check_en = 1'b1;
  endtask

  task automatic idle();
    ireset = 0; adr = 6'h00; iowe = 0; dbusout = 8'h00;
    sp_dec = 0; sp_inc = 0; sp_step = 2'd0;
    alu_flags = 8'h00; alu_flags_we = 8'h00; irq_ack = 0; reti_exec = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    idle(); iowe = 1; adr = a; dbusout = d; cyc(); idle();
  endtask

  // Literal expectation checked against both DUT and model
  task automatic lit(input string name, input int act, input int mdl, input int exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  always @(negedge cp2) begin
    if (check_en) begin
      chk("sp_out",   int'(sp_out),   m_sp);
      chk("spl_out",  int'(spl_out),  m_sp % 256);
      chk("sph_out",  int'(sph_out),  m_sp / 256);
      chk("sreg_out", int'(sreg_out), int'(m_sreg));
      chk("sp_chg",   int'(sp_chg),   int'(m_chg));
      chk("sp_ovf",   int'(sp_ovf),   int'(m_ovf));
    end
  end

  initial begin
    int sel;
    idle();
    ireset = 1;
    cyc(); cyc();
    idle(); cyc();
    lit("rst_sp",   int'(sp_out),   m_sp, 'h08FF);
    lit("rst_sph",  int'(sph_out),  m_sp / 256, 'h08);
    lit("rst_spl",  int'(spl_out),  m_sp % 256, 'hFF);
    lit("rst_sreg", int'(sreg_out), int'(m_sreg), 'h00);
    lit("rst_chg",  int'(sp_chg),   int'(m_chg), 0);
    lit("rst_ovf",  int'(sp_ovf),   int'(m_ovf), 0);

    wr(6'h3E, 8'hFF);
    lit("sph_mask", int'(sph_out), m_sp / 256, 'h0F);
    lit("chg_sph",  int'(sp_chg),  int'(m_chg), 1);
    wr(6'h3D, 8'h34);
    lit("sp_0f34",  int'(sp_out),  m_sp, 'h0F34);
    lit("chg_spl",  int'(sp_chg),  int'(m_chg), 1);
    cyc();
    lit("chg_idle", int'(sp_chg),  int'(m_chg), 0);

    wr(6'h3E, 8'h01); wr(6'h3D, 8'h01);
    sp_dec = 1; sp_step = 2; cyc(); idle();
    lit("dec_limit_sp",  int'(sp_out), m_sp, 'h00FF);
    lit("dec_limit_ovf", int'(sp_ovf), int'(m_ovf), 1);
    sp_inc = 1; sp_step = 2; cyc(); idle();
    lit("inc_sp",        int'(sp_out), m_sp, 'h0101);
    lit("ovf_sticky",    int'(sp_ovf), int'(m_ovf), 1);
    wr(6'h3E, 8'h08);
    lit("ovf_clear",     int'(sp_ovf), int'(m_ovf), 0);

    wr(6'h3E, 8'h00); wr(6'h3D, 8'h00);
    sp_dec = 1; sp_step = 1; cyc(); idle();
    lit("wrap_sp",  int'(sp_out), m_sp, 'h0FFF);
    lit("wrap_ovf", int'(sp_ovf), int'(m_ovf), 1);
    iowe = 1; adr = 6'h3D; dbusout = 8'h55; sp_dec = 1; sp_step = 1; cyc(); idle();
    lit("wr_beats_dec", int'(sp_out), m_sp, 'h0F55);
    sp_inc = 1; sp_dec = 1; sp_step = 1; cyc(); idle();
    lit("inc_dec_both", int'(sp_out), m_sp, 'h0F55);
    sp_dec = 1; sp_step = 3; cyc(); idle();
    lit("step3_none",   int'(sp_out), m_sp, 'h0F55);
    sp_inc = 1; sp_step = 2; cyc(); idle();
    sp_inc = 1; sp_step = 2; cyc(); idle();
    sp_inc = 1; sp_step = 2; cyc(); idle();
    lit("inc_f5b",      int'(sp_out), m_sp, 'h0F5B);

    wr(6'h3F, 8'h80);
    alu_flags = 8'h03; alu_flags_we = 8'h03; cyc(); idle();
    lit("alu_flags", int'(sreg_out), int'(m_sreg), 'h83);
    irq_ack = 1; alu_flags = 8'h80; alu_flags_we = 8'h80; reti_exec = 1; cyc(); idle();
    lit("irq_wins",  int'(sreg_out), int'(m_sreg), 'h03);
    reti_exec = 1; alu_flags = 8'h00; alu_flags_we = 8'h80; cyc(); idle();
    lit("reti_set",  int'(sreg_out), int'(m_sreg), 'h83);

    iowe = 1; adr = 6'h3F; dbusout = 8'h5A; alu_flags = 8'h00; alu_flags_we = 8'hFF;
    irq_ack = 1; cyc(); idle();
    lit("sreg_wr_wins", int'(sreg_out), int'(m_sreg), 'h5A);
    wr(6'h2A, 8'hC3);
    lit("other_adr", int'(sp_out), m_sp, 'h0F5B);
    ireset = 1; sp_dec = 1; sp_step = 1; cyc(); idle();
    lit("rst_mid_dec", int'(sp_out), m_sp, 'h08FF);
    cyc();

    // Randomized phase, biased toward the stack-limit and wrap regions
    for (int i = 0; i < 4000; i++) begin
      idle();
      ireset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        iowe = 1;
        sel = $urandom_range(0, 7);
        adr = (sel < 2) ? 6'h3D : (sel < 4) ? 6'h3E : (sel < 6) ? 6'h3F : 6'($urandom);
        dbusout = 8'($urandom);
        if (adr == 6'h3E && $urandom_range(0, 1) == 1) dbusout = 8'($urandom_range(0, 1));
      end else begin
        iowe = $urandom_range(0, 7) == 0;
        adr = 6'($urandom);
        dbusout = 8'($urandom);
      end
      sp_dec = $urandom_range(0, 2) == 0;
      sp_inc = $urandom_range(0, 3) == 0;
      sp_step = 2'($urandom);
      alu_flags = 8'($urandom);
      alu_flags_we = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      irq_ack = $urandom_range(0, 9) == 0;
      reti_exec = $urandom_range(0, 9) == 0;
      cyc();
    end
    idle(); cyc();
    @(negedge cp2);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_wr_core_regs.md
Name: io_wr_core_regs

Overview:
- Write-side counterpart of the core I/O read multiplexer.
- Holds the core-resident I/O registers SPL (0x3D), SPH (0x3E) and SREG (0x3F) and decodes I/O writes to them.
- Arbitrates those writes against core-internal updates: stack push/pop/call/ret stepping, ALU flag updates, and interrupt I-bit handling.
- Drives spl_out/sph_out/sreg_out into the read multiplexer and sp_out into the data-memory address path.

Parameters:
- SP_BITS, 12, number of implemented stack-pointer bits; unimplemented upper bits always read 0.
- SP_RESET, 16'h08FF, SP value after reset (RAMEND), masked to SP_BITS.
- STACK_LIMIT, 16'h0100, lowest legal SP; a decrement ending below it sets sp_ovf.

Ports:
- cp2  in  1  core clock; all state updates on rising edge.
- ireset  in  1  synchronous reset, active-high.
- adr  in  6  I/O address.
- iowe  in  1  I/O write strobe; a write is qualified when iowe=1 and adr matches.
- dbusout  in  8  write data from the core.
- sp_dec  in  1  push: SP -= sp_step.
- sp_inc  in  1  pop: SP += sp_step.
- sp_step  in  2  step size for sp_inc/sp_dec: 1 or 2 are legal; 0 or 3 means no SP change.
- alu_flags  in  8  new SREG flag values from the ALU.
- alu_flags_we  in  8  per-bit SREG update enables.
- irq_ack  in  1  interrupt accepted: clear I (bit 7).
- reti_exec  in  1  RETI executing: set I.
- spl_out  out  8  SP[7:0].
- sph_out  out  8  SP[15:8], with bits >= SP_BITS forced to 0.
- sreg_out  out  8  SREG.
- sp_out  out  16  full SP.
- sp_chg  out  1  registered one-cycle pulse: SP changed on the previous edge.
- sp_ovf  out  1  sticky stack-underflow/overflow flag.

Behaviour:
- Reset (ireset=1 at the clock edge):
  - SP = SP_RESET & mask; SREG = 8'h00; sp_chg = 0; sp_ovf = 0.
  - All other inputs are ignored that cycle.
  - An assertion in the middle of a push or write sequence discards it; no partial update survives.
- All outputs are registered; every update is visible on the outputs the cycle after the edge.
- SP write decode:
  - Qualified write to 0x3D: SP[7:0] = dbusout.
  - Qualified write to 0x3E: SP[15:8] = dbusout & upper mask.
  - A qualified SP write in a cycle suppresses sp_inc/sp_dec for that cycle entirely (I/O write wins).
- SP stepping:
  - Only when no qualified SP write is present.
  - sp_dec alone: SP = (SP - sp_step) mod 2^SP_BITS.
  - sp_inc alone: SP = (SP + sp_step) mod 2^SP_BITS.
  - sp_inc and sp_dec together: no SP change (protocol error, tolerated silently).
  - Wrap: SP=0x000 with dec 1 gives 0xFFF (SP_BITS=12); SP=0xFFF with inc 2 gives 0x001.
- sp_ovf:
  - Set when a decrement produces a result < STACK_LIMIT, or when a decrement wraps.
  - Cleared only by a qualified write to 0x3E or by reset.
  - Set and clear in the same cycle cannot occur, because a write suppresses the decrement.
- sp_chg: 1 in the cycle after any edge where the SP value actually changed (write or step); 0 otherwise.
- SREG update priority, highest first:
  1. Qualified I/O write to 0x3F: SREG = dbusout; ALU, irq_ack and reti_exec are ignored that cycle.
  2. irq_ack: I = 0, which overrides both alu_flags_we[7] and reti_exec.
  3. reti_exec: I = 1, which overrides alu_flags_we[7].
  4. ALU: for each bit b with alu_flags_we[b] = 1, SREG[b] = alu_flags[b]; bits with enable 0 hold.
- Writes to any other adr, and iowe=0, leave all state unchanged.
- Reads are not decoded here.
- A write followed by a read of the same register on the next cycle returns the new value (zero-cycle write-to-output latency after the edge).

Test Plan:
1. Reset, then idle -> sp_out=16'h08FF, sph_out=8'h08, spl_out=8'hFF, sreg_out=8'h00, sp_chg=0, sp_ovf=0.
2. iowe adr=0x3E data=8'hFF, then adr=0x3D data=8'h34 -> sph_out=8'h0F (masked), sp_out=16'h0F34; sp_chg pulses once after each write.
3. SP=16'h0101, sp_dec step=2 -> SP=16'h00FF and sp_ovf=1; then sp_inc step=2 -> SP=16'h0101 with sp_ovf still 1; then write 0x3E=8'h08 -> sp_ovf=0.
4. SP=16'h0000, sp_dec step=1 -> SP=16'h0FFF and sp_ovf=1; same cycle as a write of 0x3D=8'h55 with sp_dec -> SP low byte=8'h55, no decrement applied.
5. SREG=8'h80, alu_flags=8'h03 we=8'h03 -> 8'h83; in the same cycle irq_ack=1 with we[7]=1 and alu_flags[7]=1 -> I=0; reti_exec alone -> I=1.
6. iowe adr=0x3F data=8'h5A with alu_flags_we=8'hFF and irq_ack=1 in the same cycle -> sreg_out=8'h5A; ireset asserted during an sp_dec cycle -> SP=16'h08FF.
